// File: rtl/glb_port_arbiter.sv
// Registered round-robin arbiter sharing the single GLB SRAM port among ifmap-read,
// ipsum-read and opsum-write lanes. Optional STARVE_GUARD_EN adds per-class aging.
module glb_port_arbiter #(
  parameter int NUM_REQ    = 32,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en_i,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        ifmap_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] ifmap_addr_i,
  input  logic [NUM_REQ-1:0]        ipsum_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] ipsum_addr_i,
  input  logic [NUM_REQ-1:0]        opsum_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] opsum_addr_i,
  input  logic [NUM_REQ*4-1:0]      opsum_web_i,
  input  logic [NUM_REQ*DATA_W-1:0] opsum_wdata_i,
  output logic [NUM_REQ-1:0]        ifmap_gnt_o,
  output logic [NUM_REQ-1:0]        ipsum_gnt_o,
  output logic [NUM_REQ-1:0]        opsum_gnt_o,
  output logic                      glb_req_o,
  output logic [ADDR_W-1:0]         glb_addr_o,
  output logic [3:0]                glb_web_o,
  output logic [DATA_W-1:0]         glb_wdata_o,
  input  logic [DATA_W-1:0]         glb_rdata_i,
  output logic [NUM_REQ-1:0]        ifmap_rvalid_o,
  output logic [NUM_REQ-1:0]        ipsum_rvalid_o,
  output logic [DATA_W-1:0]         rdata_o
);

  localparam int LW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    CLS_IFMAP = 2'd0,
    CLS_IPSUM = 2'd1,
    CLS_OPSUM = 2'd2
  } cls_e;

  typedef struct packed {
    logic          vld;
    logic          ipsum;
    logic [LW-1:0] lane;
  } tag_t;

  // Returns {found, lane}: first requesting lane at or after ptr, wrapping.
  function automatic logic [LW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [LW-1:0]      ptr);
    logic [LW:0]   res;
    logic [LW-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + LW'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0][LW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    ifmap_gnt_q, ifmap_gnt_d;
  logic [NUM_REQ-1:0]    ipsum_gnt_q, ipsum_gnt_d;
  logic [NUM_REQ-1:0]    opsum_gnt_q, opsum_gnt_d;
  logic                  glb_req_q, glb_req_d;
  logic [ADDR_W-1:0]     glb_addr_q, glb_addr_d;
  logic [3:0]            glb_web_q, glb_web_d;
  logic [DATA_W-1:0]     glb_wdata_q, glb_wdata_d;
  tag_t                  cmd_tag_q, cmd_tag_d;
  tag_t [READ_LAT-1:0]   tag_pipe_q, tag_pipe_d;
  logic [NUM_REQ-1:0]    ifmap_rvalid_q, ifmap_rvalid_d;
  logic [NUM_REQ-1:0]    ipsum_rvalid_q, ipsum_rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [2:0][NUM_REQ-1:0] elig;
  logic [2:0][LW:0]        pick;
  logic [2:0]              has_req;
  logic [2:0]              win_oh;
  logic                    grant_en;
  cls_e                    win_cls;
  logic [LW-1:0]           win_lane;
  tag_t                    ret_tag;

  // A lane whose grant is high this cycle is still holding req; mask it out.
  always_comb begin
    elig[CLS_IFMAP] = ifmap_req_i & ~ifmap_gnt_q;
    elig[CLS_IPSUM] = ipsum_req_i & ~ipsum_gnt_q;
    elig[CLS_OPSUM] = opsum_req_i & ~opsum_gnt_q;
    for (int c = 0; c < 3; c++) begin
      pick[c]    = rr_pick(elig[c], ptr_q[c]);
      has_req[c] = pick[c][LW];
    end
  end

`ifdef STARVE_GUARD_EN
  logic [2:0][3:0] age_q, age_d;
  logic [2:0]      aged;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      aged[c] = has_req[c] && (age_q[c] >= 4'(STARVE_MAX));
    end
  end
`endif

  // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
  // every output gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    if (has_req[CLS_OPSUM])      win_cls = CLS_OPSUM;
    else if (has_req[CLS_IPSUM]) win_cls = CLS_IPSUM;
    else                         win_cls = CLS_IFMAP;
`ifdef STARVE_GUARD_EN
    if (aged[CLS_OPSUM])         win_cls = CLS_OPSUM;
    else if (aged[CLS_IPSUM])    win_cls = CLS_IPSUM;
    else if (aged[CLS_IFMAP])    win_cls = CLS_IFMAP;
`endif
    grant_en = arb_en_i && !flush_i && (|has_req);
    win_lane = pick[win_cls][LW-1:0];
    win_oh   = grant_en ? (3'b001 << win_cls) : 3'b000;
  end

`ifdef STARVE_GUARD_EN
  always_comb begin
    age_d = age_q;
    for (int c = 0; c < 3; c++) begin
      if (flush_i)                                                   age_d[c] = '0;
      else if (win_oh[c])                                            age_d[c] = '0;
      else if (grant_en && has_req[c] && age_q[c] < 4'(STARVE_MAX)) age_d[c] = age_q[c] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
`endif

  always_comb begin
    ptr_d       = ptr_q;
    ifmap_gnt_d = '0;
    ipsum_gnt_d = '0;
    opsum_gnt_d = '0;
    glb_req_d   = 1'b0;
    glb_addr_d  = '0;
    glb_web_d   = 4'hF;
    glb_wdata_d = '0;
    cmd_tag_d   = '0;
    if (flush_i) begin
      ptr_d = '0;
    end else if (grant_en) begin
      ptr_d[win_cls] = win_lane + LW'(1);
      glb_req_d      = 1'b1;
      case (win_cls)
        CLS_OPSUM: begin
          opsum_gnt_d[win_lane] = 1'b1;
          glb_addr_d  = opsum_addr_i[int'(win_lane)*ADDR_W +: ADDR_W];
          glb_web_d   = opsum_web_i[int'(win_lane)*4 +: 4];
          glb_wdata_d = opsum_wdata_i[int'(win_lane)*DATA_W +: DATA_W];
        end
        CLS_IPSUM: begin
          ipsum_gnt_d[win_lane] = 1'b1;
          glb_addr_d      = ipsum_addr_i[int'(win_lane)*ADDR_W +: ADDR_W];
          cmd_tag_d.vld   = 1'b1;
          cmd_tag_d.ipsum = 1'b1;
          cmd_tag_d.lane  = win_lane;
        end
        default: begin
          ifmap_gnt_d[win_lane] = 1'b1;
          glb_addr_d      = ifmap_addr_i[int'(win_lane)*ADDR_W +: ADDR_W];
          cmd_tag_d.vld   = 1'b1;
          cmd_tag_d.ipsum = 1'b0;
          cmd_tag_d.lane  = win_lane;
        end
      endcase
    end
  end

  // The command register holds the tag for the cycle the GLB sees the read; the
  // pipe then delays it READ_LAT cycles to line up with glb_rdata_i.
  always_comb begin
    tag_pipe_d[0] = cmd_tag_q;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
    ret_tag        = tag_pipe_q[READ_LAT-1];
    ifmap_rvalid_d = '0;
    ipsum_rvalid_d = '0;
    rdata_d        = glb_rdata_i;
    if (flush_i) begin
      tag_pipe_d = '0;
      rdata_d    = '0;
    end else if (ret_tag.vld) begin
      if (ret_tag.ipsum) ipsum_rvalid_d[ret_tag.lane] = 1'b1;
      else               ifmap_rvalid_d[ret_tag.lane] = 1'b1;
    end
  end

  // NOTE: the tag pipe must be reset, otherwise stale tags raise rvalid after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      ifmap_gnt_q    <= '0;
      ipsum_gnt_q    <= '0;
      opsum_gnt_q    <= '0;
      glb_req_q      <= 1'b0;
      glb_addr_q     <= '0;
      glb_web_q      <= 4'hF;
      glb_wdata_q    <= '0;
      cmd_tag_q      <= '0;
      tag_pipe_q     <= '0;
      ifmap_rvalid_q <= '0;
      ipsum_rvalid_q <= '0;
      rdata_q        <= '0;
    end else begin
      ptr_q          <= ptr_d;
      ifmap_gnt_q    <= ifmap_gnt_d;
      ipsum_gnt_q    <= ipsum_gnt_d;
      opsum_gnt_q    <= opsum_gnt_d;
      glb_req_q      <= glb_req_d;
      glb_addr_q     <= glb_addr_d;
      glb_web_q      <= glb_web_d;
      glb_wdata_q    <= glb_wdata_d;
      cmd_tag_q      <= cmd_tag_d;
      tag_pipe_q     <= tag_pipe_d;
      ifmap_rvalid_q <= ifmap_rvalid_d;
      ipsum_rvalid_q <= ipsum_rvalid_d;
      rdata_q        <= rdata_d;
    end
  end

  assign ifmap_gnt_o    = ifmap_gnt_q;
  assign ipsum_gnt_o    = ipsum_gnt_q;
  assign opsum_gnt_o    = opsum_gnt_q;
  assign glb_req_o      = glb_req_q;
  assign glb_addr_o     = glb_addr_q;
  assign glb_web_o      = glb_web_q;
  assign glb_wdata_o    = glb_wdata_q;
  assign ifmap_rvalid_o = ifmap_rvalid_q;
  assign ipsum_rvalid_o = ipsum_rvalid_q;
  assign rdata_o        = rdata_q;

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Directed bench for glb_port_arbiter with a GLB memory model and a read-return scoreboard.
// Honours STARVE_GUARD_EN to pick the expected starvation outcome.
module tb_glb_port_arbiter;
  localparam int NUM_REQ  = 32;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;

  typedef struct packed {
    logic        ipsum;
    logic [7:0]  lane;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      arb_en = 1'b0;
  logic                      flush = 1'b0;
  logic [NUM_REQ-1:0]        ifmap_req = '0, ipsum_req = '0, opsum_req = '0;
  logic [NUM_REQ*ADDR_W-1:0] ifmap_addr = '0, ipsum_addr = '0, opsum_addr = '0;
  logic [NUM_REQ*4-1:0]      opsum_web = '1;
  logic [NUM_REQ*DATA_W-1:0] opsum_wdata = '0;
  logic [NUM_REQ-1:0]        ifmap_gnt, ipsum_gnt, opsum_gnt;
  logic                      glb_req;
  logic [ADDR_W-1:0]         glb_addr;
  logic [3:0]                glb_web;
  logic [DATA_W-1:0]         glb_wdata;
  logic [DATA_W-1:0]         glb_rdata;
  logic [NUM_REQ-1:0]        ifmap_rvalid, ipsum_rvalid;
  logic [DATA_W-1:0]         rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  exp_t sb[$];

  glb_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .STARVE_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .arb_en_i(arb_en), .flush_i(flush),
    .ifmap_req_i(ifmap_req), .ifmap_addr_i(ifmap_addr),
    .ipsum_req_i(ipsum_req), .ipsum_addr_i(ipsum_addr),
    .opsum_req_i(opsum_req), .opsum_addr_i(opsum_addr),
    .opsum_web_i(opsum_web), .opsum_wdata_i(opsum_wdata),
    .ifmap_gnt_o(ifmap_gnt), .ipsum_gnt_o(ipsum_gnt), .opsum_gnt_o(opsum_gnt),
    .glb_req_o(glb_req), .glb_addr_o(glb_addr), .glb_web_o(glb_web),
    .glb_wdata_o(glb_wdata), .glb_rdata_i(glb_rdata),
    .ifmap_rvalid_o(ifmap_rvalid), .ipsum_rvalid_o(ipsum_rvalid), .rdata_o(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // GLB model: two-stage read pipe (READ_LAT = 2), byte-masked writes.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_p1 = '0, rd_p2 = '0;
  assign glb_rdata = rd_p2;

  always @(posedge clk) begin : glb_model
    logic [31:0] w;
    if (glb_req && glb_web != 4'hF) begin
      w = mem.exists(glb_addr) ? mem[glb_addr] : init_word(glb_addr);
      for (int b = 0; b < 4; b++) if (!glb_web[b]) w[8*b +: 8] = glb_wdata[8*b +: 8];
      mem[glb_addr] = w;
    end
    if (glb_req && glb_web == 4'hF)
      rd_p1 <= mem.exists(glb_addr) ? mem[glb_addr] : init_word(glb_addr);
    else
      rd_p1 <= '0;
    rd_p2 <= rd_p1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard: pops when the expected return cycle arrives.
  always @(negedge clk) begin : rv_monitor
    exp_t               e;
    logic [NUM_REQ-1:0] oh;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.lane] = 1'b1;
        check("rv_ifmap", ifmap_rvalid, e.ipsum ? '0 : oh);
        check("rv_ipsum", ipsum_rvalid, e.ipsum ? oh : '0);
        check("rv_data", rdata, e.data);
      end else begin
        check("rv_idle", {ifmap_rvalid, ipsum_rvalid}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input bit is_ipsum, input int lane, input logic [31:0] data);
    exp_t e;
    e.ipsum = is_ipsum;
    e.lane  = 8'(lane);
    e.data  = data;
    e.cyc   = cyc + READ_LAT + 1;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int                 lanes[4] = '{0, 3, 7, 0};
    int                 first_if;
    logic [NUM_REQ-1:0] prev_op;

    // Reset state
    arb_en = 1'b1;
    repeat (3) tick();
    check("rst_gnt", {ifmap_gnt, ipsum_gnt}, 64'd0);
    check("rst_ogn", opsum_gnt, 0);
    check("rst_req", glb_req, 0);
    check("rst_web", glb_web, 4'hF);
    check("rst_addr", glb_addr, 0);
    check("rst_rv", {ifmap_rvalid, ipsum_rvalid}, 64'd0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    check("idle_req", glb_req, 0);
    check("idle_web", glb_web, 4'hF);

    // Single ifmap read on lane 5
    ifmap_req[5] = 1'b1;
    ifmap_addr[5*ADDR_W +: ADDR_W] = 32'h100;
    tick();
    check("t1_gnt", ifmap_gnt, 32'h0000_0020);
    check("t1_req", glb_req, 1);
    check("t1_addr", glb_addr, 32'h100);
    check("t1_web", glb_web, 4'hF);
    check("t1_other", {ipsum_gnt, opsum_gnt}, 64'd0);
    expect_rd(1'b0, 5, init_word(32'h100));
    tick();
    check("t1_mask", ifmap_gnt, 0);
    check("t1_mask_req", glb_req, 0);
    ifmap_req[5] = 1'b0;
    drain("t1");

    // Round-robin over ifmap lanes 0,3,7 from pointer 0
    flush = 1'b1;
    tick();
    flush = 1'b0;
    foreach (lanes[k]) begin
      ifmap_req[lanes[k]] = 1'b1;
      ifmap_addr[lanes[k]*ADDR_W +: ADDR_W] = 32'h200 + 32'(lanes[k] * 4);
    end
    for (int k = 0; k < 4; k++) begin
      logic [NUM_REQ-1:0] oh;
      tick();
      oh = '0;
      oh[lanes[k]] = 1'b1;
      check("t2_rr_gnt", ifmap_gnt, oh);
      check("t2_rr_addr", glb_addr, 32'h200 + 32'(lanes[k] * 4));
      expect_rd(1'b0, lanes[k], init_word(32'h200 + 32'(lanes[k] * 4)));
    end
    ifmap_req = '0;
    drain("t2");

    // Opsum write beats a same-cycle ipsum read; read then sees the written word
    opsum_req[2] = 1'b1;
    opsum_addr[2*ADDR_W +: ADDR_W] = 32'h300;
    opsum_web[2*4 +: 4] = 4'h0;
    opsum_wdata[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    ipsum_req[1] = 1'b1;
    ipsum_addr[1*ADDR_W +: ADDR_W] = 32'h300;
    tick();
    check("t3_op_gnt", opsum_gnt, 32'h0000_0004);
    check("t3_ip_wait", ipsum_gnt, 0);
    check("t3_web", glb_web, 4'h0);
    check("t3_wdata", glb_wdata, 32'hDEAD_BEEF);
    check("t3_waddr", glb_addr, 32'h300);
    opsum_req[2] = 1'b0;
    tick();
    check("t3_ip_gnt", ipsum_gnt, 32'h0000_0002);
    check("t3_op_idle", opsum_gnt, 0);
    check("t3_rd_web", glb_web, 4'hF);
    check("t3_rd_addr", glb_addr, 32'h300);
    expect_rd(1'b1, 1, 32'hDEAD_BEEF);
    ipsum_req[1] = 1'b0;
    drain("t3");

    // Flush one cycle after a read grant drops the read and resets pointers
    ifmap_req[4] = 1'b1;
    ifmap_addr[4*ADDR_W +: ADDR_W] = 32'h400;
    tick();
    check("t4_gnt", ifmap_gnt, 32'h0000_0010);
    ifmap_req[4] = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_fl_gnt", ifmap_gnt, 0);
    check("t4_fl_req", glb_req, 0);
    check("t4_fl_web", glb_web, 4'hF);
    repeat (4) tick();
    ifmap_req[0] = 1'b1;
    ifmap_addr[0 +: ADDR_W] = 32'h410;
    ifmap_req[6] = 1'b1;
    ifmap_addr[6*ADDR_W +: ADDR_W] = 32'h418;
    tick();
    check("t4_ptr0", ifmap_gnt, 32'h0000_0001);
    expect_rd(1'b0, 0, init_word(32'h410));
    ifmap_req[0] = 1'b0;
    tick();
    check("t4_next", ifmap_gnt, 32'h0000_0040);
    expect_rd(1'b0, 6, init_word(32'h418));
    ifmap_req[6] = 1'b0;
    drain("t4");

    // arb_en low: no new commands, in-flight read still returns
    ifmap_req[9] = 1'b1;
    ifmap_addr[9*ADDR_W +: ADDR_W] = 32'h500;
    tick();
    check("t5_gnt", ifmap_gnt, 32'h0000_0200);
    expect_rd(1'b0, 9, init_word(32'h500));
    ifmap_req[9] = 1'b0;
    arb_en = 1'b0;
    ipsum_req[3] = 1'b1;
    ipsum_addr[3*ADDR_W +: ADDR_W] = 32'h700;
    opsum_req[4] = 1'b1;
    opsum_addr[4*ADDR_W +: ADDR_W] = 32'h704;
    opsum_web[4*4 +: 4] = 4'h3;
    opsum_wdata[4*DATA_W +: DATA_W] = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_off_req", glb_req, 0);
      check("t5_off_gnt", ifmap_gnt | ipsum_gnt | opsum_gnt, 0);
    end
    check("t5_returned", 64'(sb.size()), 64'd0);
    arb_en = 1'b1;
    tick();
    check("t5_on_op", opsum_gnt, 32'h0000_0010);
    check("t5_on_web", glb_web, 4'h3);
    opsum_req[4] = 1'b0;
    tick();
    check("t5_on_ip", ipsum_gnt, 32'h0000_0008);
    expect_rd(1'b1, 3, init_word(32'h700));
    ipsum_req[3] = 1'b0;
    drain("t5");

    // Saturated opsum load against one ifmap requester
    for (int l = 0; l < NUM_REQ; l++) begin
      opsum_addr[l*ADDR_W +: ADDR_W]   = 32'h1000 + 32'(l * 4);
      opsum_web[l*4 +: 4]              = 4'h0;
      opsum_wdata[l*DATA_W +: DATA_W]  = 32'(l);
    end
    opsum_req = '1;
    ifmap_req[1] = 1'b1;
    ifmap_addr[1*ADDR_W +: ADDR_W] = 32'h600;
    first_if = -1;
    prev_op = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("t6_no_repeat", opsum_gnt & prev_op, 0);
      prev_op = opsum_gnt;
      if (ifmap_gnt != '0 && first_if < 0) begin
        first_if = k;
        check("t6_if_gnt", ifmap_gnt, 32'h0000_0002);
        expect_rd(1'b0, 1, init_word(32'h600));
        ifmap_req[1] = 1'b0;
      end
    end
`ifdef STARVE_GUARD_EN
    check("t6_starve_at", 64'(first_if), 64'(16));
`else
    check("t6_starved", 64'(first_if), 64'(-1));
`endif
    opsum_req = '0;
    ifmap_req = '0;
    tick();
    drain("t6");

    repeat (3) tick();
    check("final_sb", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
